// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Memory-side responder for the memory stage's data-memory request port.
// Owns a byte-wide data array and services one 64-bit little-endian read or
// write per transaction, moving one byte per clock. The initiator therefore
// sees real multi-cycle latency (9 cycles for a legal access and 1 cycle for
// a rejected one) and stalls on the valid/ready handshakes.
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_n_i       asynchronous active-low reset (array contents are kept)
//   req_valid_i   request present
//   req_ready_o   request can be accepted this cycle (IDLE only)
//   req_we_i      1 = write, 0 = read
//   req_addr_i    byte address of the lowest byte
//   req_wdata_i   write data
//   resp_valid_o  response present
//   resp_ready_i  initiator accepts the response
//   resp_rdata_o  read data, 0 for writes and errors
//   resp_error_o  access rejected (address out of range)
//   busy_o        transaction in progress
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, addresses with addr[2:0] != 0 are also
//                        rejected through the error path.
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int MEM_BYTES  = 1024,
  parameter int INIT_BYTES = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [63:0] resp_rdata_o,
  output logic        resp_error_o,
  output logic        busy_o
);

  localparam int          IDX_W      = $clog2(MEM_BYTES);
  localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - 8);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Power-up image: the first INIT_BYTES locations hold their own index.
  function automatic logic [MEM_BYTES*8-1:0] mem_image();
    logic [MEM_BYTES*8-1:0] img;
    img = '0;
    for (int i = 0; i < INIT_BYTES; i++) begin
      img[i*8 +: 8] = 8'(i);
    end
    return img;
  endfunction

  // Flat byte array; only written by the ACCESS engine, never by reset.
  logic [MEM_BYTES*8-1:0] mem_q = mem_image();

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  logic              addr_ok;
  logic [IDX_W-1:0]  byte_idx;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;
  logic              mem_we;

  // Full 64-bit compare so huge addresses cannot wrap into the array.
  always_comb begin
    addr_ok = (req_addr_i <= LAST_LEGAL);
`ifdef DMEM_ALIGN_CHECK_EN
    addr_ok = addr_ok && (req_addr_i[2:0] == 3'b000);
`endif
  end

  // addr_q <= MEM_BYTES-8 is guaranteed in ACCESS, so addr_q+k never overflows.
  assign byte_idx = addr_q + IDX_W'(cnt_q);
  assign rd_byte  = mem_q[{byte_idx, 3'b000} +: 8];
  assign wr_byte  = wdata_q[{cnt_q, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i[IDX_W-1:0];
          wdata_d = req_wdata_i;
          rdata_d = '0;
          cnt_d   = '0;
          if (addr_ok) begin
            state_d = ACCESS;
            error_d = 1'b0;
          end else begin
            state_d = RESP;
            error_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          mem_we = 1'b1;
        end else begin
          rdata_d[{cnt_q, 3'b000} +: 8] = rd_byte;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready_i) begin
          state_d = IDLE;
          rdata_d = '0;
          error_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers: async reset aborts any transaction.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Latched request fields: only meaningful after an accept, no reset needed.
  always_ff @(posedge clk_i) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Byte write port; mem_we is low whenever reset holds the FSM in IDLE.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[{byte_idx, 3'b000} +: 8] <= wr_byte;
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign resp_rdata_o = rdata_q;
  assign resp_error_o = error_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. Each request computes its expected
// response (data, error flag, latency) from a byte-level reference model and
// pushes it to a scoreboard queue; the entry is popped and compared when the
// DUT presents its response. Inputs are driven and outputs sampled on the
// falling clock edge.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int MEM_BYTES  = 1024;
  localparam int INIT_BYTES = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_error;
  logic        busy;

  always #5 clk = ~clk;

  dmem_responder #(
    .MEM_BYTES (MEM_BYTES),
    .INIT_BYTES(INIT_BYTES)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),
    .resp_error_o(resp_error),
    .busy_o      (busy)
  );

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model[MEM_BYTES];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic addr_err(input logic [63:0] a);
    logic e;
    e = (a > 64'(MEM_BYTES - 8));
`ifdef DMEM_ALIGN_CHECK_EN
    e = e | (a[2:0] != 3'b000);
`endif
    return e;
  endfunction

  // Reference model: build the expected response and apply legal writes.
  task automatic push_exp(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    exp_t e;
    int   base;
    e.err   = addr_err(addr);
    e.lat   = e.err ? 1 : 9;
    e.rdata = '0;
    if (!e.err) begin
      base = int'(addr[31:0]);
      for (int k = 0; k < 8; k++) begin
        if (we) model[base+k] = wdata[8*k +: 8];
        else    e.rdata[8*k +: 8] = model[base+k];
      end
    end
    sb.push_back(e);
  endtask

  // One full transaction; stall = cycles resp_ready is held low in RESP.
  task automatic do_req(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input int stall);
    exp_t        e;
    int          lat;
    logic [63:0] held;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    push_exp(we, addr, wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    check("resp_valid", 64'(resp_valid), 64'd1);
    check("latency", 64'(lat), 64'(e.lat));
    check("rdata", resp_rdata, e.rdata);
    check("error", 64'(resp_error), 64'(e.err));
    held = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(resp_valid), 64'd1);
      check("stall_rdata", resp_rdata, held);
      check("stall_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_req_ready", 64'(req_ready), 64'd1);
    check("post_resp_valid", 64'(resp_valid), 64'd0);
    check("post_rdata", resp_rdata, 64'd0);
    check("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    for (int i = 0; i < MEM_BYTES; i++) model[i] = (i < INIT_BYTES) ? 8'(i) : 8'h00;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;

    // Reset values while held and after release
    repeat (3) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_error", 64'(resp_error), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 64'(req_ready), 64'd1);
    check("rel_resp_valid", 64'(resp_valid), 64'd0);
    check("rel_busy", 64'(busy), 64'd0);

    // Initial contents, write/readback, unaligned read
    do_req(1'b0, 64'h0, 64'h0, 0);
    do_req(1'b1, 64'h20, 64'hDEADBEEF_CAFEF00D, 0);
    do_req(1'b0, 64'h20, 64'h0, 0);
    do_req(1'b0, 64'h21, 64'h0, 0);

    // Range boundary and error path
    do_req(1'b0, 64'd1020, 64'h0, 0);
    do_req(1'b0, 64'd1017, 64'h0, 0);
    do_req(1'b1, 64'd1020, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    do_req(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'hA5A5_A5A5_A5A5_A5A5, 0);
    do_req(1'b1, 64'h1_0000_0000, 64'h5A5A_5A5A_5A5A_5A5A, 0);
    do_req(1'b0, 64'd1016, 64'h0, 0);

    // Response backpressure
    do_req(1'b1, 64'd1016, 64'h0123_4567_89AB_CDEF, 3);
    do_req(1'b0, 64'd1016, 64'h0, 3);

    // Alignment (error when the align check is built in)
    do_req(1'b0, 64'd3, 64'h0, 0);

    // Reset three ACCESS cycles into a write
    check("mw_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 64'h40;
    req_wdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_busy", 64'(busy), 64'd1);
      check("mw_no_resp", 64'(resp_valid), 64'd0);
    end
    rst_n = 1'b0;
    #1;
    check("mw_rst_busy", 64'(busy), 64'd0);
    check("mw_rst_req_ready", 64'(req_ready), 64'd1);
    check("mw_rst_resp_valid", 64'(resp_valid), 64'd0);
    model[16'h40] = 8'h88;
    model[16'h41] = 8'h77;
    model[16'h42] = 8'h66;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_after_no_resp", 64'(resp_valid), 64'd0);
    end
    do_req(1'b0, 64'h40, 64'h0, 0);
    do_req(1'b0, 64'h3C, 64'h0, 0);

    // Random aligned write/readback pairs
    for (int n = 0; n < 6; n++) begin
      a = 64'($urandom_range(0, (MEM_BYTES / 8) - 1)) << 3;
      d = {$urandom, $urandom};
      do_req(1'b1, a, d, 0);
      do_req(1'b0, a, 64'h0, n % 2);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data-memory request interface driven by the memory stage.
- Owns a byte-wide data array and services one 64-bit read or write per transaction over a valid/ready request/response handshake.
- Moves one byte per cycle, little-endian, so the stage can stall on real multi-cycle memory latency.
- Sits between the memory stage (initiator) and the data storage; replaces the zero-latency array path for multi-cycle configurations.

Parameters:
- MEM_BYTES, 1024, number of byte locations in the array (index 0..MEM_BYTES-1).
- INIT_BYTES, 16, locations 0..INIT_BYTES-1 initialised to their own index (8'h00..8'h0F); all other locations initialised to 0.

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request present
- req_ready_o  out  1  responder can accept a request this cycle
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  64  byte address of the lowest byte
- req_wdata_i  in  64  write data
- resp_valid_o  out  1  response present
- resp_ready_i  in  1  initiator accepts the response
- resp_rdata_o  out  64  read data; 0 for writes and errors
- resp_error_o  out  1  access rejected (address out of range)
- busy_o  out  1  a transaction is in progress (state != IDLE)

Behaviour:
- Reset is asynchronous, active-low, single clock (clk_i). While rst_n_i = 0:
  - state = IDLE, byte counter = 0.
  - req_ready_o = 1, resp_valid_o = 0, resp_rdata_o = 0, resp_error_o = 0, busy_o = 0.
  - Array contents are not affected by reset.
- States are IDLE, ACCESS and RESP.
- IDLE:
  - req_ready_o = 1.
  - Handshake fires on a rising edge with req_valid_i = 1: latch we, addr and wdata; clear rdata; clear counter.
  - Address legal means addr <= MEM_BYTES-8, compared in the full 64 bits with no wrap.
  - Legal address: go to ACCESS.
  - Illegal address: go to RESP with error = 1, rdata = 0, and no array access.
- ACCESS:
  - req_ready_o = 0. Counter k runs 0..7, one byte per cycle.
  - Write: mem[addr+k] <= wdata[8k+7:8k].
  - Read: rdata[8k+7:8k] <= mem[addr+k].
  - After k = 7, go to RESP.
  - Incoming req_valid_i is ignored; the initiator must hold it until req_ready_o = 1.
- RESP:
  - resp_valid_o = 1; resp_rdata_o and resp_error_o are held stable.
  - On resp_ready_i = 1, go to IDLE next cycle.
  - While resp_ready_i = 0, stay in RESP with outputs frozen.
- Latency, counted from the accept edge to the first cycle resp_valid_o = 1:
  - Legal access: 9 cycles.
  - Error: 1 cycle.
- No request pipelining: a new request is accepted no earlier than the cycle after the response handshake.
- Writes also produce a response: rdata = 0, error = 0.
- Transactions are serialised, so read-after-write to the same address returns the new data.
- Reset mid-ACCESS:
  - Abort immediately to IDLE and drop the response.
  - Bytes already written stay written; unwritten bytes keep their old values.
- resp_rdata_o and resp_error_o are cleared on entry to IDLE.

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN.
- Defined: a request with addr[2:0] != 0 is also illegal. It takes the error path (RESP after 1 cycle, error = 1, no array access).
- Undefined: any legal-range address is accepted regardless of alignment.

Test Plan:
- Reset: hold rst_n_i low, then release -> req_ready_o = 1, resp_valid_o = 0, busy_o = 0, rdata = 0, error = 0.
- Read of initial contents at addr 0 -> resp_valid_o asserts 9 cycles after accept; rdata = 64'h0706050403020100, error = 0.
- Write 64'hDEADBEEF_CAFEF00D to addr 0x20, then read addr 0x20 -> write response rdata = 0; read returns 64'hDEADBEEFCAFEF00D. A read at 0x21 returns 64'h00DEADBEEFCAFEF0.
- Read at addr 1020, then addr 1017 -> each gives error = 1 and rdata = 0, 1 cycle after accept. Addr 1016 succeeds; mem[1016..1023] unchanged by the error requests.
- Backpressure: hold resp_ready_i = 0 for 3 cycles in RESP -> resp_valid_o and rdata stay stable, req_ready_o stays 0. After the handshake, req_ready_o = 1 next cycle.
- Reset mid-write: assert rst_n_i low after 3 ACCESS cycles of writing 64'h1122334455667788 to addr 0x40.
  - Expect mem[0x40..0x42] = 88, 77, 66 and mem[0x43..0x47] = 00.
  - Expect resp_valid_o never asserted.
  - With DMEM_ALIGN_CHECK_EN, a read at addr 3 -> error = 1.
